// File: rtl/pipeline_issue_pkg.sv
// Shared widths and helpers for the issue stage at the head of the address pipeline.
package pipeline_issue_pkg;

   localparam int unsigned ADDRESS_WIDTH       = 32;
   localparam int unsigned ID_WIDTH            = 3;
   localparam int unsigned DEF_MAX_OUTSTANDING = 8;

   // Width of a counter that must hold 0..max_out inclusive.
   function automatic int unsigned cnt_width(input int unsigned max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage

// File: rtl/pipeline_issue_if.sv
// Request handshake carrying addresses into the issue stage.
interface pipeline_issue_if
   import pipeline_issue_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDRESS_WIDTH
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_address;

   modport master (output req_valid, output req_address, input  req_ready);
   modport slave  (input  req_valid, input  req_address, output req_ready);
endinterface

// File: rtl/pipeline_issue_id_tracker.sv
// Transaction ID allocator: busy bitmap, next_id counter, outstanding count, sticky retire error.
module pipeline_issue_id_tracker
   import pipeline_issue_pkg::*;
#(
   parameter int unsigned ID_W            = ID_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
   parameter int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             alloc,
   input  logic             release_a,
   input  logic [ID_W-1:0]  release_a_id,
   input  logic             release_b,
   input  logic [ID_W-1:0]  release_b_id,
   output logic [ID_W-1:0]  next_id,
   output logic             busy_next,
   output logic [CNT_W-1:0] outstanding,
   output logic             err
);
   localparam int unsigned NUM_IDS = 1 << ID_W;

   logic [NUM_IDS-1:0] busy;
   logic [NUM_IDS-1:0] busy_d;
   logic [CNT_W-1:0]   outstanding_d;
   logic               hit_a;
   logic               hit_b;
   logic               same_id;
   logic [1:0]         dec;

   assign busy_next = busy[next_id];

   // Releases only count against IDs that are actually in flight; a double release of one ID counts once.
   always_comb begin
      busy_d        = busy;
      hit_a         = release_a && busy[release_a_id];
      hit_b         = release_b && busy[release_b_id];
      same_id       = release_a_id == release_b_id;
      dec           = 2'(hit_a) + 2'(hit_b && !(hit_a && same_id));
      if (hit_a) busy_d[release_a_id] = 1'b0;
      if (hit_b) busy_d[release_b_id] = 1'b0;
      if (alloc) busy_d[next_id]      = 1'b1;
      outstanding_d = outstanding + CNT_W'(alloc) - CNT_W'(dec);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy        <= '0;
         next_id     <= '0;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         busy        <= busy_d;
         outstanding <= outstanding_d;
         if (alloc) next_id <= next_id + ID_W'(1);
         if (release_a && !busy[release_a_id]) err <= 1'b1;
      end
   end
endmodule

// File: rtl/pipeline_issue.sv
// Issue stage: accepts requests, tags them with IDs, feeds stage 0 and forwards flush commands.
module pipeline_issue
   import pipeline_issue_pkg::*;
#(
   parameter int unsigned ADDR_W          = ADDRESS_WIDTH,
   parameter int unsigned ID_W            = ID_WIDTH,
   parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   pipeline_issue_if.slave                        req,
   input  logic                                   cmd_flush,
   input  logic [ID_W-1:0]                        cmd_flush_id,
   input  logic                                   retire_valid,
   input  logic [ID_W-1:0]                        retire_id,
   input  logic                                   in_stall,
   output logic [ADDR_W-1:0]                      out_address,
   output logic [ID_W-1:0]                        out_id,
   output logic                                   out_valid,
   output logic                                   out_flush,
   output logic [ID_W-1:0]                        out_flush_id,
   output logic [cnt_width(MAX_OUTSTANDING)-1:0]  outstanding,
   output logic                                   err_retire
);
   localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

   logic [ID_W-1:0] next_id;
   logic            busy_next;
   logic            accept;
   logic            kill_held;

   pipeline_issue_id_tracker #(
      .ID_W            (ID_W),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
   ) u_tracker (
      .clk          (clk),
      .reset_n      (reset_n),
      .alloc        (accept),
      .release_a    (retire_valid),
      .release_a_id (retire_id),
      .release_b    (cmd_flush),
      .release_b_id (cmd_flush_id),
      .next_id      (next_id),
      .busy_next    (busy_next),
      .outstanding  (outstanding),
      .err          (err_retire)
   );

   // No same-cycle retire bypass: readiness depends on registered state only.
   assign req.req_ready = !in_stall && !cmd_flush && !busy_next &&
                          (outstanding < CNT_W'(MAX_OUTSTANDING));
   assign accept        = req.req_valid && req.req_ready;
   assign kill_held     = cmd_flush && out_valid && (out_id == cmd_flush_id);

   // Output register toward stage 0; a flush of the held ID turns a stalled slot into a bubble.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_address <= '0;
         out_id      <= '0;
         out_valid   <= 1'b0;
      end else if (!in_stall) begin
         out_address <= accept ? req.req_address : '0;
         out_id      <= accept ? next_id : '0;
         out_valid   <= accept;
      end else if (kill_held) begin
         out_address <= '0;
         out_id      <= '0;
         out_valid   <= 1'b0;
      end
   end

   // Flush chain ignores the stall so a flush is never lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_flush    <= 1'b0;
         out_flush_id <= '0;
      end else begin
         out_flush    <= cmd_flush;
         out_flush_id <= cmd_flush_id;
      end
   end
endmodule

// File: tb/tb_pipeline_issue.sv
// Self-checking bench for pipeline_issue: directed table, corner sequences, random traffic vs a set-based model.
module tb_pipeline_issue;
   localparam int unsigned AW = 32;
   localparam int unsigned IW = 3;
   localparam int unsigned NIDS = 8;
   localparam int unsigned MAXO = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          cmd_flush = 1'b0;
   logic [IW-1:0] cmd_flush_id = '0;
   logic          retire_valid = 1'b0;
   logic [IW-1:0] retire_id = '0;
   logic          in_stall = 1'b0;
   logic [AW-1:0] out_address;
   logic [IW-1:0] out_id;
   logic          out_valid;
   logic          out_flush;
   logic [IW-1:0] out_flush_id;
   logic [3:0]    outstanding;
   logic          err_retire;

   pipeline_issue_if #(.ADDR_W(AW)) req_if ();

   pipeline_issue #(.ADDR_W(AW), .ID_W(IW), .MAX_OUTSTANDING(MAXO)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req          (req_if),
      .cmd_flush    (cmd_flush),
      .cmd_flush_id (cmd_flush_id),
      .retire_valid (retire_valid),
      .retire_id    (retire_id),
      .in_stall     (in_stall),
      .out_address  (out_address),
      .out_id       (out_id),
      .out_valid    (out_valid),
      .out_flush    (out_flush),
      .out_flush_id (out_flush_id),
      .outstanding  (outstanding),
      .err_retire   (err_retire)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the set of in-flight IDs plus the visible output slot.
   logic [NIDS-1:0] m_busy;
   int              m_nid;
   logic            m_ov;
   logic [AW-1:0]   m_oa;
   logic [IW-1:0]   m_oid;
   logic            m_of;
   logic [IW-1:0]   m_ofid;
   logic            m_err;
   logic            ready_seen;

   typedef struct {
      logic          v;
      logic [AW-1:0] a;
      logic          st;
      logic          e_ready;
      logic          e_valid;
      logic [AW-1:0] e_addr;
      logic [IW-1:0] e_id;
      int            e_out;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = '0; m_nid = 0; m_ov = 0; m_oa = '0; m_oid = '0;
      m_of = 0; m_ofid = '0; m_err = 0;
   endtask

   task automatic check_outputs();
      chk("out_valid",    64'(out_valid),    64'(m_ov));
      chk("out_address",  64'(out_address),  64'(m_oa));
      chk("out_id",       64'(out_id),       64'(m_oid));
      chk("out_flush",    64'(out_flush),    64'(m_of));
      chk("out_flush_id", 64'(out_flush_id), 64'(m_ofid));
      chk("outstanding",  64'(outstanding),  64'($countones(m_busy)));
      chk("err_retire",   64'(err_retire),   64'(m_err));
   endtask

   // One clock: drive, check readiness, clock, advance model, check registered outputs.
   task automatic cycle(input logic v, input logic [AW-1:0] a, input logic f, input logic [IW-1:0] fid,
                        input logic rv, input logic [IW-1:0] rid, input logic st);
      logic            exp_ready;
      logic            acc;
      logic [NIDS-1:0] pre;
      req_if.req_valid = v; req_if.req_address = a;
      cmd_flush = f; cmd_flush_id = fid;
      retire_valid = rv; retire_id = rid; in_stall = st;
      #1;
      exp_ready  = !st && !f && !m_busy[m_nid] && ($countones(m_busy) < MAXO);
      ready_seen = req_if.req_ready;
      chk("req_ready", 64'(ready_seen), 64'(exp_ready));
      acc = v && exp_ready;
      @(posedge clk);
      #1;
      pre = m_busy;
      if (!st) begin
         m_ov = acc; m_oa = acc ? a : '0; m_oid = acc ? IW'(m_nid) : '0;
      end else if (f && m_ov && m_oid == fid) begin
         m_ov = 0; m_oa = '0; m_oid = '0;
      end
      m_of = f; m_ofid = fid;
      if (rv) begin
         if (pre[rid]) m_busy[rid] = 1'b0;
         else m_err = 1'b1;
      end
      if (f && pre[fid]) m_busy[fid] = 1'b0;
      if (acc) begin
         m_busy[m_nid] = 1'b1;
         m_nid = (m_nid + 1) % NIDS;
      end
      check_outputs();
   endtask

   task automatic idle(input logic v);
      cycle(v, 32'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
   endtask

   initial begin
      // Directed table: three back-to-back issues, a fourth, a 4-cycle stall, then a bubble.
      vecs[0] = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 32'h10, 3'd0, 1};
      vecs[1] = '{1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 32'h20, 3'd1, 2};
      vecs[2] = '{1'b1, 32'h30, 1'b0, 1'b1, 1'b1, 32'h30, 3'd2, 3};
      vecs[3] = '{1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 32'h40, 3'd3, 4};
      for (int i = 4; i < 8; i++)
         vecs[i] = '{1'b1, 32'h50, 1'b1, 1'b0, 1'b1, 32'h40, 3'd3, 4};
      vecs[8] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0, 4};

      req_if.req_valid = 1'b0; req_if.req_address = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      reset_n = 1'b1;
      #2;

      for (int i = 0; i < 9; i++) begin
         cycle(vecs[i].v, vecs[i].a, 1'b0, 3'd0, 1'b0, 3'd0, vecs[i].st);
         chk("tbl_ready", 64'(ready_seen),  64'(vecs[i].e_ready));
         chk("tbl_valid", 64'(out_valid),   64'(vecs[i].e_valid));
         chk("tbl_addr",  64'(out_address), 64'(vecs[i].e_addr));
         chk("tbl_id",    64'(out_id),      64'(vecs[i].e_id));
         chk("tbl_outst", 64'(outstanding), 64'(vecs[i].e_out));
      end

      // Fill to the limit: IDs 4..7 bring the count to 8 and next_id wraps onto busy ID 0.
      for (int i = 0; i < 4; i++) cycle(1'b1, 32'h50 + 32'(i), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("full_outst", 64'(outstanding), 64'd8);
      idle(1'b1);
      chk("full_ready", 64'(ready_seen), 64'd0);
      cycle(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 3'd3, 1'b0);
      chk("ret3_outst", 64'(outstanding), 64'd7);
      idle(1'b1);
      chk("wrap_block_ready", 64'(ready_seen), 64'd0);
      for (int i = 1; i < 8; i++)
         if (i != 3) cycle(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, IW'(i), 1'b0);
      chk("only0_outst", 64'(outstanding), 64'd1);
      idle(1'b1);
      chk("only0_ready", 64'(ready_seen), 64'd0);
      cycle(1'b1, 32'h0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("flush0_outst", 64'(outstanding), 64'd0);
      chk("flush0_fl", 64'(out_flush), 64'd1);
      cycle(1'b1, 32'h99, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("reissue0_id", 64'(out_id), 64'd0);
      chk("reissue0_valid", 64'(out_valid), 64'd1);

      // Flush of the held ID while stalled becomes a bubble.
      for (int i = 1; i <= 5; i++) cycle(1'b1, 32'h100 + 32'(i), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("pre_kill_id", 64'(out_id), 64'd5);
      chk("pre_kill_outst", 64'(outstanding), 64'd6);
      cycle(1'b1, 32'h0, 1'b1, 3'd5, 1'b0, 3'd0, 1'b1);
      chk("kill_valid", 64'(out_valid), 64'd0);
      chk("kill_flush", 64'(out_flush), 64'd1);
      chk("kill_flush_id", 64'(out_flush_id), 64'd5);
      chk("kill_outst", 64'(outstanding), 64'd5);

      // Retire of an idle ID is sticky; retire+flush of the same ID counts once.
      cycle(1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 3'd7, 1'b0);
      chk("err_set", 64'(err_retire), 64'd1);
      idle(1'b0);
      chk("err_sticky", 64'(err_retire), 64'd1);
      cycle(1'b0, 32'h0, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0);
      chk("dual_rel_outst", 64'(outstanding), 64'd4);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 7) == 0), IW'($urandom),
               ($urandom_range(0, 2) == 0), IW'($urandom), ($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset in mid-cycle clears everything at once.
      idle(1'b1);
      req_if.req_valid = 1'b0;
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("rst_ready", 64'(req_if.req_ready), 64'd1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cycle(1'b1, 32'hABC, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
      chk("post_rst_id", 64'(out_id), 64'd0);
      chk("post_rst_outst", 64'(outstanding), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
